// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern modes and bounce direction.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_PWM    = 2'd3
    } mode_e;

    localparam mode_e MODE_RESET = MODE_COUNT;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler: counts enabled cycles and flags the cycle that
// completes each 2^LOG2DELAY window (combinational step condition).
module led_prescaler #(
    parameter int LOG2DELAY = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic [LOG2DELAY-1:0] count,
    output logic                 step
);

    logic [LOG2DELAY-1:0] count_q;
    logic [LOG2DELAY-1:0] count_d;

    // Advance only while enabled; wraps naturally from all-ones to zero.
    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign step  = enable & (&count_q);

endmodule

// File: rtl/led_pattern_gen.sv
// Counter-driven LED pattern generator: binary count, walking one, bounce and
// PWM breathing on CHANNELS outputs, one pattern step per prescaler window.
// The requested mode is only sampled on a step; a changed mode starts from its
// initial state, an unchanged mode advances.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int LOG2DELAY = 25,
    parameter int PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] led,
    output logic                tick,
    output logic [1:0]          mode_active
);

    logic [LOG2DELAY-1:0] pre_count;
    logic                 step;

    led_prescaler #(
        .LOG2DELAY (LOG2DELAY)
    ) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .count  (pre_count),
        .step   (step)
    );

    // Only the low PWM_BITS of the prescaler feed the duty comparison.
    logic pre_unused;
    assign pre_unused = ^pre_count;

    mode_e                mode_req;
    mode_e                mode_active_q, mode_active_d;
    logic [CHANNELS-1:0]  cnt_q,         cnt_d;
    logic [CHANNELS-1:0]  onehot_q,      onehot_d;
    dir_e                 dir_q,         dir_d;
    logic [PWM_BITS-1:0]  duty_q,        duty_d;
    logic [CHANNELS-1:0]  led_q,         led_d;
    logic                 tick_q,        tick_d;
    logic                 pwm_on;

    assign mode_req = mode_e'(mode);

    // Pattern state update on step events, and the next LED value every enabled cycle.
    always_comb begin
        mode_active_d = mode_active_q;
        cnt_d         = cnt_q;
        onehot_d      = onehot_q;
        dir_d         = dir_q;
        duty_d        = duty_q;
        led_d         = led_q;
        tick_d        = step;
        pwm_on        = 1'b0;

        if (step) begin
            mode_active_d = mode_req;
            if (mode_req != mode_active_q) begin
                unique case (mode_req)
                    MODE_COUNT:  cnt_d = '0;
                    MODE_WALK:   onehot_d = CHANNELS'(1);
                    MODE_BOUNCE: begin
                        onehot_d = CHANNELS'(1);
                        dir_d    = DIR_UP;
                    end
                    MODE_PWM:    duty_d = '0;
                endcase
            end else begin
                unique case (mode_active_q)
                    MODE_COUNT:  cnt_d = cnt_q + CHANNELS'(1);
                    MODE_WALK:   onehot_d = (onehot_q << 1) | (onehot_q >> (CHANNELS - 1));
                    MODE_BOUNCE: begin
                        // A single channel has nowhere to move; it simply stays lit.
                        if (CHANNELS == 1) begin
                            onehot_d = onehot_q;
                        end else if (dir_q == DIR_UP) begin
                            if (onehot_q[CHANNELS-1]) begin
                                dir_d    = DIR_DOWN;
                                onehot_d = onehot_q >> 1;
                            end else begin
                                onehot_d = onehot_q << 1;
                            end
                        end else begin
                            if (onehot_q[0]) begin
                                dir_d    = DIR_UP;
                                onehot_d = onehot_q << 1;
                            end else begin
                                onehot_d = onehot_q >> 1;
                            end
                        end
                    end
                    MODE_PWM:    duty_d = duty_q + PWM_BITS'(1);
                endcase
            end
        end

        // On a step the prescaler low bits are all ones, so the PWM output is
        // off regardless of duty; using duty_d keeps the entry value at 0.
        pwm_on = (pre_count[PWM_BITS-1:0] < duty_d);

        if (enable) begin
            unique case (mode_active_d)
                MODE_COUNT:  led_d = cnt_d;
                MODE_WALK:   led_d = onehot_d;
                MODE_BOUNCE: led_d = onehot_d;
                MODE_PWM:    led_d = {CHANNELS{pwm_on}};
            endcase
        end
    end

    // Pattern and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_active_q <= MODE_RESET;
            cnt_q         <= '0;
            onehot_q      <= CHANNELS'(1);
            dir_q         <= DIR_UP;
            duty_q        <= '0;
            led_q         <= '0;
            tick_q        <= 1'b0;
        end else begin
            mode_active_q <= mode_active_d;
            cnt_q         <= cnt_d;
            onehot_q      <= onehot_d;
            dir_q         <= dir_d;
            duty_q        <= duty_d;
            led_q         <= led_d;
            tick_q        <= tick_d;
        end
    end

    assign led         = led_q;
    assign tick        = tick_q;
    assign mode_active = mode_active_q;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised, counter-driven LED/IO pattern generator for board bring-up and constraint-test designs. It generalises the fixed "free-running counter shifted onto four LEDs" scheme to N channels, a configurable prescaler and four selectable patterns: binary count, walking one, bounce and PWM breathing. It sits between the board clock and the output-buffer layer (OBUF/OBUFTDS instances in the top level). The block itself is pure RTL with no primitives.

## Interface
Parameters:
- `CHANNELS`, 4, number of LED outputs; legal range 1..32.
- `LOG2DELAY`, 25, prescaler width; one pattern step every 2^LOG2DELAY enabled cycles; legal range 2..32.
- `PWM_BITS`, 4, PWM resolution; requires PWM_BITS ≤ LOG2DELAY.

Ports:
- `clk`  in  1  board clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  high: prescaler runs; low: all state frozen.
- `mode`  in  2  requested pattern: 0 COUNT, 1 WALK, 2 BOUNCE, 3 PWM.
- `led`  out  CHANNELS  registered pattern output.
- `tick`  out  1  one-cycle pulse marking each pattern step.
- `mode_active`  out  2  mode currently in effect (registered).

## Operation
- **Prescaler**
  - LOG2DELAY-bit counter `pre`; increments by 1 each cycle `enable`=1; wraps all-ones→0.
  - Step event: `enable`=1 and `pre`=all-ones.
- **Step event**
  - Registers `tick`=1 for exactly one cycle, then 0.
  - Samples `mode` into `mode_active`.
  - If `mode` ≠ `mode_active`, reinitialise the new mode's state. Otherwise advance the current mode.
  - `mode` is ignored between step events.
- **Initial states**
  - COUNT: cnt=0.
  - WALK: one-hot=1.
  - BOUNCE: one-hot=1, dir=up.
  - PWM: duty=0.
- **COUNT:** cnt (CHANNELS bits) += 1 per step, modulo 2^CHANNELS. `led`=cnt.
- **WALK:** rotate left one position per step; MSB wraps to bit 0. `led`=one-hot.
- **BOUNCE:** shift in the current direction.
  - At bit CHANNELS-1 going up, reverse and shift down.
  - At bit 0 going down, reverse and shift up.
  - No repeated end state: 0001,0010,0100,1000,0100,0010,0001,0010…
- **PWM:** duty (PWM_BITS) += 1 per step, wrapping.
  - Every cycle (not only on steps): `led` = all bits equal to (`pre[PWM_BITS-1:0]` < duty).
  - duty=0 gives `led` constantly 0.
- **CHANNELS=1:** WALK and BOUNCE hold `led`=1.
- **`enable`=0:** `pre`, pattern state, `led`, `mode_active` hold; `tick`=0.
- **Reset (rst_n=0, any time, including mid-step):**
  - `pre`=0, `mode_active`=COUNT, cnt=0, `led`=0, `tick`=0.
  - One-hot register=1, dir=up, duty=0.

## Timing
- First step event occurs 2^LOG2DELAY enabled cycles after reset release. `tick` and the new `led` value appear on the following edge, in the same cycle.
- Step period is exactly 2^LOG2DELAY enabled cycles. Disabled cycles stretch the period without losing phase.
- A mode change takes effect at the first step event after `mode` changes: the latency is 1..2^LOG2DELAY cycles. The first `led` value in the new mode is that mode's initial state (COUNT shows 0, WALK/BOUNCE show 1).
- PWM output latency is 1 cycle from `pre`.

## Structure
- **Package `led_pattern_pkg`:**
  - Enum `mode_e` (MODE_COUNT=0, MODE_WALK=1, MODE_BOUNCE=2, MODE_PWM=3).
  - Reset constant `MODE_RESET = MODE_COUNT`.
- **Sub-module `led_prescaler`:** parameter LOG2DELAY.
  - Ports: clk, rst_n, enable, count out, step out (combinational step condition).
  - Instantiated once. The pattern logic stays in `led_pattern_gen`.

## Test plan
All runs use CHANNELS=4, LOG2DELAY=3, PWM_BITS=2.
- **Reset and COUNT:** reset, enable=1, mode=0. `led`=0 until the first tick at cycle 8. Then 1,2,…,15,0 with one tick every 8 cycles. Assert rst_n mid-period: `led`=0 and `tick`=0 immediately.
- **WALK:** switch mode=1. At the next tick `led`=0001, `mode_active`=1. Next steps: 0010,0100,1000,0001.
- **BOUNCE:** mode=2. Steps show 0001,0010,0100,1000,0100,0010,0001,0010.
- **PWM:** mode=3.
  - duty=0: `led`=0000 for all 8 cycles.
  - duty=1: `led`=1111 for 2 of 8 cycles, following pre[1:0] phase 0.
  - duty=3: `led`=1111 for 6 of 8 cycles.
- **Enable gating:** drop `enable` for 5 cycles mid-period. `led` and `pre` hold and `tick` stays 0. The next tick arrives exactly 5 cycles late.
- **Mode glitch:** toggle `mode` 0→2→0 between ticks. At the next tick `mode_active` stays 0 and COUNT continues advancing with no reinitialisation.
